vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_timing_gen_if.sv | 32 +++
 rtl/tick_delay_line.sv | 37 +++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the timing generator and its bench.
package vga_timing_pkg;

    // Horizontal timing, in pixel ticks
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

    // Vertical timing, in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

    // First and last coordinate of each sync pulse (inclusive)
    localparam int H_SYNC_FIRST = H_VISIBLE + H_FRONT;                 // 656
    localparam int H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;           // 751
    localparam int V_SYNC_FIRST = V_VISIBLE + V_FRONT;                 // 490
    localparam int V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;           // 491

    // Both sync outputs are active-low
    localparam logic SYNC_ACTIVE = 1'b0;

    // Index of each signal in the delayed {hsync, vsync, de} bundle
    localparam int BIT_HSYNC = 2;
    localparam int BIT_VSYNC = 1;
    localparam int BIT_DE    = 0;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator and the frame-buffer / DAC side.
//
// Timing contract (no valid/ready: the generator never stalls): every output
// changes only on the clk edge that ends a cycle with pix_tick=1, so a
// consumer samples pix_x/pix_y/frame_start in the pix_tick cycle. color_in
// must carry the pixel for the coordinate presented PIPE_LAT ticks earlier
// and be stable at the clk edge ending each pix_tick cycle.
interface vga_timing_gen_if #(
    parameter int SCREEN_WIDTH = 10
);
    logic [11:0]             color_in;
    logic [SCREEN_WIDTH-1:0] pix_x;
    logic [SCREEN_WIDTH-1:0] pix_y;
    logic                    pix_tick;
    logic                    frame_start;
    logic                    hsync;
    logic                    vsync;
    logic                    de;
    logic [11:0]             rgb;

    // Timing generator side
    modport master (
        input  color_in,
        output pix_x, pix_y, pix_tick, frame_start, hsync, vsync, de, rgb
    );

    // Frame-buffer / DAC side
    modport slave (
        output color_in,
        input  pix_x, pix_y, pix_tick, frame_start, hsync, vsync, de, rgb
    );
endinterface

// File: rtl/tick_delay_line.sv
// Tick-qualified shift register; DEPTH=0 degenerates to a plain wire.
module tick_delay_line #(
    parameter int               WIDTH = 1,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Clock, reset and enable are not needed without storage
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, en};
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift one stage per enable; reset loads the inactive value everywhere
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
                end else if (en) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA 640x480 timing generator: pixel prescaler, x/y counters, sync/de decode,
// pipeline-matched sync delay and the registered RGB output stage.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int PIPE_LAT     = 2,
    parameter int SCREEN_WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int                    CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]         DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [SCREEN_WIDTH-1:0] X_LAST   = SCREEN_WIDTH'(H_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] Y_LAST   = SCREEN_WIDTH'(V_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] X_VIS    = SCREEN_WIDTH'(H_VISIBLE);
    localparam logic [SCREEN_WIDTH-1:0] Y_VIS    = SCREEN_WIDTH'(V_VISIBLE);
    localparam logic [SCREEN_WIDTH-1:0] X_SYNC_F = SCREEN_WIDTH'(H_SYNC_FIRST);
    localparam logic [SCREEN_WIDTH-1:0] X_SYNC_L = SCREEN_WIDTH'(H_SYNC_LAST);
    localparam logic [SCREEN_WIDTH-1:0] Y_SYNC_F = SCREEN_WIDTH'(V_SYNC_FIRST);
    localparam logic [SCREEN_WIDTH-1:0] Y_SYNC_L = SCREEN_WIDTH'(V_SYNC_LAST);
    localparam logic [2:0]            SYNC_IDLE = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

    // run stays low for the first clk after reset release so that the first
    // pix_tick lands exactly CLK_DIV clks after release, also for CLK_DIV=1.
    logic                    run;
    logic [CW-1:0]           div_cnt;
    logic                    tick;
    logic [SCREEN_WIDTH-1:0] pix_x;
    logic [SCREEN_WIDTH-1:0] pix_y;
    logic [2:0]              sync_raw;
    logic [2:0]              sync_dly;
    logic [11:0]             rgb_q;

    // Pixel prescaler: counts 0..CLK_DIV-1 once running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            div_cnt <= '0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign tick = run && (div_cnt == DIV_LAST);

    // Raster counters: x advances per tick, y advances when x wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (tick) begin
            if (pix_x == X_LAST) begin
                pix_x <= '0;
                pix_y <= (pix_y == Y_LAST) ? '0 : pix_y + 1'b1;
            end else begin
                pix_x <= pix_x + 1'b1;
            end
        end
    end

    // Undelayed sync/de decode of the current coordinate; de is held off
    // while not running so a zero-depth delay line still reads 0 in reset.
    always_comb begin
        sync_raw            = SYNC_IDLE;
        sync_raw[BIT_HSYNC] = (pix_x >= X_SYNC_F && pix_x <= X_SYNC_L) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        sync_raw[BIT_VSYNC] = (pix_y >= Y_SYNC_F && pix_y <= Y_SYNC_L) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        sync_raw[BIT_DE]    = run && (pix_x < X_VIS) && (pix_y < Y_VIS);
    end

    // Align sync/de with the frame-buffer read latency
    tick_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_LAT),
        .INIT  (SYNC_IDLE)
    ) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick),
        .din   (sync_raw),
        .dout  (sync_dly)
    );

    // Output pixel register: blank outside the delayed display window.
    // Being a register, rgb trails the delayed de by one pixel tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= 12'h000;
        end else if (tick) begin
            rgb_q <= sync_dly[BIT_DE] ? vga.color_in : 12'h000;
        end
    end

    assign vga.pix_x       = pix_x;
    assign vga.pix_y       = pix_y;
    assign vga.pix_tick    = tick;
    assign vga.frame_start = tick && (pix_x == '0) && (pix_y == '0);
    assign vga.hsync       = sync_dly[BIT_HSYNC];
    assign vga.vsync       = sync_dly[BIT_VSYNC];
    assign vga.de          = sync_dly[BIT_DE];
    assign vga.rgb         = rgb_q;

endmodule
